alu_result_checker: RTL and testbench

//  Hardware scoreboard on the receiving end of the ALU operand/opcode stream:

---
 rtl/alu_result_checker.sv | 137 +++++++++++++
 tb/tb_alu_result_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker: ALU scoreboard; pipelined golden model compared against ALU outputs LATENCY cycles later.
// Define ALU_CHK_STATUS_EN to also compare the Status flags.
module alu_result_checker #(
  parameter int WIDTH    = 32,
  parameter int LATENCY  = 1,
  parameter bit STOP_ERR = 1'b0
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             Stop,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic [5:0]       OPCode,
  input  logic [WIDTH-1:0] ResultC,
  input  logic [3:0]       Status,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic             Mismatch,
  output logic [31:0]      CheckCount,
  output logic [15:0]      ErrCount,
  output logic [5:0]       FirstOp,
  output logic [WIDTH-1:0] FirstExp,
  output logic [WIDTH-1:0] FirstGot
);
  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;
  localparam logic [2:0] LAST = 3'(LATENCY - 1);
  state_t           state, nxt;
  logic [2:0]       fcnt;
  logic [WIDTH:0]   sum_add, sum_sub;
  logic             is_add, is_sub, is_and, is_or, is_xor;
  logic             exp_v;
  logic [WIDTH-1:0] exp_res;
  logic             pv   [LATENCY];
  logic [5:0]       pop  [LATENCY];
  logic [WIDTH-1:0] pres [LATENCY];
  logic             match, do_chk, bad;
  logic [31:0]      chk_n;
  logic [15:0]      err_n;
  assign sum_add = {1'b0, DataA} + {1'b0, DataB};
  assign sum_sub = {1'b0, DataA} + {1'b0, ~DataB} + (WIDTH+1)'(1);
  assign is_add  = OPCode == 6'b010000;
  assign is_sub  = OPCode == 6'b010001;
  assign is_and  = OPCode == 6'b010010;
  assign is_or   = OPCode == 6'b001100;
  assign is_xor  = OPCode == 6'b001101;
  assign exp_v   = is_add | is_sub | is_and | is_or | is_xor;
  assign exp_res = is_add ? sum_add[WIDTH-1:0] :
                   is_sub ? sum_sub[WIDTH-1:0] :
                   is_and ? DataA & DataB :
                   is_or  ? DataA | DataB :
                   is_xor ? DataA ^ DataB : '0;
`ifdef ALU_CHK_STATUS_EN
  logic       exp_o, exp_c;
  logic [3:0] exp_flags;
  logic [3:0] pflg [LATENCY];
  assign exp_c = is_add ? sum_add[WIDTH] : is_sub ? sum_sub[WIDTH] : 1'b0;
  assign exp_o = is_add ? (DataA[WIDTH-1] == DataB[WIDTH-1]) && (exp_res[WIDTH-1] != DataA[WIDTH-1]) :
                 is_sub ? (DataA[WIDTH-1] != DataB[WIDTH-1]) && (exp_res[WIDTH-1] != DataA[WIDTH-1]) : 1'b0;
  assign exp_flags = {exp_o, exp_c, exp_res == '0, exp_res[WIDTH-1]};
  assign match = pres[LATENCY-1] == ResultC && pflg[LATENCY-1] == Status;
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      for (int i = 0; i < LATENCY; i++) pflg[i] <= '0;
    end else begin
      pflg[0] <= exp_flags;
      for (int i = 1; i < LATENCY; i++) pflg[i] <= pflg[i-1];
    end
`else
  logic unused_bits;
  assign unused_bits = ^{Status, sum_add[WIDTH], sum_sub[WIDTH]};
  assign match = pres[LATENCY-1] == ResultC;
`endif
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv[i]   <= 1'b0;
        pop[i]  <= '0;
        pres[i] <= '0;
      end
    end else begin
      pv[0]   <= exp_v;
      pop[0]  <= OPCode;
      pres[0] <= exp_res;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i]   <= pv[i-1];
        pop[i]  <= pop[i-1];
        pres[i] <= pres[i-1];
      end
    end
  assign do_chk = state == CHECK && pv[LATENCY-1];
  assign bad    = do_chk && !match;
  assign chk_n  = Start ? '0 : (do_chk && ~&CheckCount) ? CheckCount + 32'd1 : CheckCount;
  assign err_n  = Start ? '0 : (bad && ~&ErrCount) ? ErrCount + 16'd1 : ErrCount;
  // Start outranks everything; Stop before CHECK ends the run without compares
  always_comb begin
    nxt = state;
    nxt = Start ? FILL :
          ((state == IDLE || state == FILL) && Stop) ? DONE :
          (state == FILL && fcnt == LAST) ? CHECK :
          (state == CHECK && (Stop || (STOP_ERR && bad))) ? DONE : state;
  end
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      fcnt       <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Pass       <= 1'b0;
      Mismatch   <= 1'b0;
      CheckCount <= '0;
      ErrCount   <= '0;
      FirstOp    <= '0;
      FirstExp   <= '0;
      FirstGot   <= '0;
    end else begin
      fcnt       <= Start ? 3'd0 : state == FILL ? fcnt + 3'd1 : fcnt;
      Busy       <= nxt == FILL || nxt == CHECK;
      Done       <= nxt == DONE;
      Pass       <= nxt == DONE && err_n == '0;
      Mismatch   <= bad && !Start;
      CheckCount <= chk_n;
      ErrCount   <= err_n;
      if (Start) begin
        FirstOp  <= '0;
        FirstExp <= '0;
        FirstGot <= '0;
      end else if (bad && ErrCount == '0) begin
        FirstOp  <= pop[LATENCY-1];
        FirstExp <= pres[LATENCY-1];
        FirstGot <= ResultC;
      end
    end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed bench for alu_result_checker (LATENCY=1), plus a STOP_ERR=1 instance on the same stimulus.
module tb_alu_result_checker;
  localparam logic [5:0] ADD = 6'b010000, SUB = 6'b010001, NOP = 6'b111111;
`ifdef ALU_CHK_STATUS_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  logic        Clock = 1'b0, ResetN = 1'b0, Start = 1'b0, Stop = 1'b0;
  logic [31:0] DataA = '0, DataB = '0, ResultC = '0;
  logic [5:0]  OPCode = NOP;
  logic [3:0]  Status = '0;
  logic        Busy, Done, Pass, Mismatch;
  logic [31:0] CheckCount, FirstExp, FirstGot;
  logic [15:0] ErrCount;
  logic [5:0]  FirstOp;
  logic        s_busy, s_done, s_pass, s_mis;
  logic [31:0] s_cnt, s_exp, s_got;
  logic [15:0] s_err;
  logic [5:0]  s_op;
  int checks = 0, errors = 0;
  always #5 Clock = ~Clock;
  alu_result_checker dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Stop(Stop),
    .DataA(DataA), .DataB(DataB), .OPCode(OPCode), .ResultC(ResultC), .Status(Status),
    .Busy(Busy), .Done(Done), .Pass(Pass), .Mismatch(Mismatch),
    .CheckCount(CheckCount), .ErrCount(ErrCount),
    .FirstOp(FirstOp), .FirstExp(FirstExp), .FirstGot(FirstGot)
  );
  alu_result_checker #(.STOP_ERR(1'b1)) dut_s (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Stop(Stop),
    .DataA(DataA), .DataB(DataB), .OPCode(OPCode), .ResultC(ResultC), .Status(Status),
    .Busy(s_busy), .Done(s_done), .Pass(s_pass), .Mismatch(s_mis),
    .CheckCount(s_cnt), .ErrCount(s_err),
    .FirstOp(s_op), .FirstExp(s_exp), .FirstGot(s_got)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] rc, input logic [3:0] st, input logic stp);
    OPCode = op; DataA = a; DataB = b; ResultC = rc; Status = st; Stop = stp;
    @(posedge Clock); #1;
    Stop = 1'b0;
  endtask
  task automatic start_run(input logic stp);
    Start = 1'b1;
    cyc(NOP, 0, 0, 0, 0, stp);
    Start = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_cnt", CheckCount, 0);
    chk("rst_err", ErrCount, 0);
    ResetN = 1'b1;
    cyc(NOP, 0, 0, 0, 0, 0);
    chk("idle_busy", Busy, 0);
    // 1: 20 correct ADDs, A=10k B=5+20k -> sum 5+30k, result one cycle later
    start_run(0);
    chk("t1_busy_fill", Busy, 1);
    for (int k = 0; k < 20; k++) begin
      cyc(ADD, 32'(10*k), 32'(5+20*k), (k == 0) ? 32'd0 : 32'(5+30*(k-1)), 4'd0, k == 19);
      if (k == 5) chk("t1_busy", Busy, 1);
    end
    chk("t1_done", Done, 1);
    chk("t1_pass", Pass, 1);
    chk("t1_busy_end", Busy, 0);
    chk("t1_cnt", CheckCount, 19);
    chk("t1_err", ErrCount, 0);
    // 2: SUB 5-5 with Zero flag wrongly 0
    start_run(0);
    cyc(SUB, 5, 5, 0, 0, 0);
    cyc(NOP, 0, 0, 0, 4'b0100, 0);
    chk("t2_mis", Mismatch, SEN);
    chk("t2_err", ErrCount, SEN);
    cyc(NOP, 0, 0, 0, 0, 1);
    chk("t2_mis_pulse", Mismatch, 0);
    chk("t2_pass", Pass, !SEN);
    chk("t2_done", Done, 1);
    // Start and Stop together: Start wins
    start_run(1);
    chk("ss_busy", Busy, 1);
    chk("ss_done", Done, 0);
    // Stop in FILL
    cyc(NOP, 0, 0, 0, 0, 1);
    chk("sf_done", Done, 1);
    chk("sf_cnt", CheckCount, 0);
    chk("sf_pass", Pass, 1);
    // 3: overflow ADD with faulty result, then a second error
    start_run(0);
    cyc(ADD, 32'h7FFFFFFF, 1, 0, 0, 0);
    cyc(ADD, 1, 1, 0, 4'b1001, 0);
    chk("t3_mis", Mismatch, 1);
    chk("t3_err", ErrCount, 1);
    chk("t3_op", FirstOp, ADD);
    chk("t3_exp", FirstExp, 32'h80000000);
    chk("t3_got", FirstGot, 0);
    cyc(NOP, 0, 0, 5, 0, 0);
    chk("t3_err2", ErrCount, 2);
    chk("t3_exp_sticky", FirstExp, 32'h80000000);
    chk("t3_cnt", CheckCount, 2);
    // 6: asynchronous reset mid-CHECK
    #2 ResetN = 1'b0;
    #1;
    chk("t6_busy", Busy, 0);
    chk("t6_mis", Mismatch, 0);
    chk("t6_err", ErrCount, 0);
    chk("t6_cnt", CheckCount, 0);
    chk("t6_exp", FirstExp, 0);
    chk("t6_op", FirstOp, 0);
    @(posedge Clock); #1;
    ResetN = 1'b1;
    start_run(0);
    chk("t6_fill", Busy, 1);
    cyc(ADD, 1, 2, 0, 0, 0);
    cyc(NOP, 0, 0, 3, 0, 1);
    chk("t6_cnt_after", CheckCount, 1);
    chk("t6_pass_after", Pass, 1);
    // 5: NOPs with garbage results are never compared
    start_run(0);
    cyc(ADD, 1, 2, 0, 0, 0);
    cyc(NOP, 0, 0, 3, 0, 0);
    for (int k = 0; k < 10; k++) cyc(NOP, $urandom, $urandom, $urandom | 32'h1000, 4'($urandom), 0);
    chk("t5_cnt", CheckCount, 1);
    chk("t5_err", ErrCount, 0);
    cyc(NOP, 0, 0, 0, 0, 1);
    chk("t5_pass", Pass, 1);
    // 4: STOP_ERR instance halts on the 3rd compare
    start_run(0);
    cyc(ADD, 1, 1, 0, 0, 0);
    cyc(ADD, 2, 2, 2, 0, 0);
    cyc(ADD, 3, 3, 4, 0, 0);
    cyc(ADD, 4, 4, 99, 0, 0);
    chk("t4_done", s_done, 1);
    chk("t4_pass", s_pass, 0);
    chk("t4_cnt", s_cnt, 3);
    chk("t4_err", s_err, 1);
    chk("t4_got", s_got, 99);
    chk("t4_exp", s_exp, 6);
    chk("t4_run_done", Done, 0);
    cyc(NOP, 0, 0, 99, 0, 0);
    chk("t4_cnt_hold", s_cnt, 3);
    chk("t4_err_hold", s_err, 1);
    chk("t4_run_cnt", CheckCount, 4);
    chk("t4_run_err", ErrCount, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
